// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the control unit and the instruction/data memories.
// master: control unit (drives requests), slave: memory side (drives acks).
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with HALT and ERROR,
// state-gated datapath control fields and a bounded memory-ack wait counter.
// Optional build macro CU_TRAP_EN: illegal opcodes trap to ERROR (err=1, illegal=1);
// without it they retire as a NOP.
//
// state    | meaning
// FETCH    | imem_req held until imem_ack, wait counter running
// DECODE   | IR/PC+1 load strobes, opcode sampled from the IR
// EXEC     | ALU/branch fields driven, brvalid for jumps/branches/syscall
// MEM      | dmem_req held until dmem_ack, rdata (LW) or wdata (SW)
// WB       | regwt for one cycle
// HALT     | halted=1 until resume
// ERROR    | err=1, everything else idle, sticky until reset
module multicycle_control_unit #(
  parameter int OP_W   = 5,
  parameter int TO_CYC = 15
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [OP_W-1:0]                  i_op,
  input  logic                             i_resume,
  multicycle_control_unit_if.master        mem_if,
  output logic                             o_irwrite,
  output logic                             o_pcwrite,
  output logic                             o_brvalid,
  output logic                             o_regwt,
  output logic                             o_alusrc,
  output logic                             o_addsub,
  output logic                             o_rdata,
  output logic                             o_wdata,
  output logic [1:0]                       o_regdst,
  output logic [1:0]                       o_reginsrc,
  output logic [1:0]                       o_brtype,
  output logic [1:0]                       o_pcsrc,
  output logic [1:0]                       o_fnc,
  output logic [1:0]                       o_lgc,
  output logic [1:0]                       o_shift,
  output logic                             o_halted,
  output logic                             o_err,
  output logic                             o_illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]      r_state, w_state_nxt;
  logic [OP_W-1:0] r_op, w_op;
  logic [7:0]      r_cnt;
  logic            r_illegal;
  logic            w_wait, w_ack, w_timeout;
  logic [4:0]      w_op5, w_alu_sel;
  logic            w_hi_ok, w_ralu, w_ialu, w_alu, w_j, w_jr, w_jal;
  logic            w_bltz, w_bz, w_bgtz, w_lw, w_sw, w_sys, w_ill, w_brv_op;
  logic [1:0]      w_regdst, w_reginsrc, w_brtype, w_pcsrc, w_fnc, w_lgc, w_shift;
  logic            w_alusrc, w_addsub, w_run, w_fld_en;

  // In DECODE the IR output is decoded directly; afterwards the latched copy is used.
  assign w_op = (r_state == S_DECODE) ? i_op : r_op;

  // Opcode class decode; anything with bits above bit 4 set is illegal.
  always_comb begin
    w_op5     = w_op[4:0];
    w_hi_ok   = (w_op >> 5) == '0;
    w_ralu    = w_hi_ok && (w_op5 <= 5'h09);
    w_ialu    = w_hi_ok && (w_op5 >= 5'h0A) && (w_op5 <= 5'h13);
    w_alu     = w_ralu || w_ialu;
    w_j       = w_hi_ok && (w_op5 == 5'h14);
    w_jr      = w_hi_ok && (w_op5 == 5'h15);
    w_jal     = w_hi_ok && (w_op5 == 5'h16);
    w_bltz    = w_hi_ok && (w_op5 == 5'h17);
    w_bz      = w_hi_ok && (w_op5 == 5'h18);
    w_bgtz    = w_hi_ok && (w_op5 == 5'h19);
    w_lw      = w_hi_ok && (w_op5 == 5'h1A);
    w_sw      = w_hi_ok && (w_op5 == 5'h1B);
    w_sys     = w_hi_ok && (w_op5 == 5'h1F);
    w_ill     = !(w_alu || w_j || w_jr || w_jal || w_bltz || w_bz || w_bgtz ||
                  w_lw || w_sw || w_sys);
    // JAL jumps as well as linking, so it strobes the branch unit too.
    w_brv_op  = w_j || w_jr || w_jal || w_bltz || w_bz || w_bgtz || w_sys;
    w_alu_sel = w_ralu ? w_op5 : w_op5 - 5'd10;
  end

  // Datapath control fields for the current opcode (ungated).
  always_comb begin
    w_regdst   = 2'b00;
    w_reginsrc = 2'b00;
    w_brtype   = 2'b00;
    w_pcsrc    = 2'b00;
    w_fnc      = 2'b00;
    w_lgc      = 2'b00;
    w_shift    = 2'b00;
    w_alusrc   = 1'b0;
    w_addsub   = 1'b0;
    if (w_alu) begin
      w_regdst   = w_ralu ? 2'b01 : 2'b00;
      w_reginsrc = 2'b01;
      w_alusrc   = w_ialu;
      // ALU op order within each class: ADD SUB AND OR XOR NOR SLT SLR SLL SAR
      case (w_alu_sel)
        5'd1: w_addsub = 1'b1;
        5'd2: begin w_fnc = 2'b11; w_lgc = 2'b00; end
        5'd3: begin w_fnc = 2'b11; w_lgc = 2'b01; end
        5'd4: begin w_fnc = 2'b11; w_lgc = 2'b10; end
        5'd5: begin w_fnc = 2'b11; w_lgc = 2'b11; end
        5'd6: begin w_fnc = 2'b01; w_addsub = 1'b1; end
        5'd7: begin w_fnc = 2'b10; w_shift = 2'b00; end
        5'd8: begin w_fnc = 2'b10; w_shift = 2'b01; end
        5'd9: begin w_fnc = 2'b10; w_shift = 2'b10; end
        default: ;
      endcase
    end
    if (w_j || w_jal) w_pcsrc = 2'b01;
    if (w_jr)         w_pcsrc = 2'b10;
    if (w_sys)        w_pcsrc = 2'b11;
    if (w_jal) begin
      w_regdst   = 2'b10;
      w_reginsrc = 2'b10;
    end
    if (w_bz)         w_brtype = 2'b01;
    if (w_bgtz)       w_brtype = 2'b10;
    if (w_bltz)       w_brtype = 2'b11;
    if (w_lw || w_sw) w_alusrc = 1'b1;
  end

  assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack     = (r_state == S_FETCH) ? mem_if.imem_ack : mem_if.dmem_ack;
  // An ack in the last permitted cycle still completes the access.
  assign w_timeout = w_wait && !w_ack && (r_cnt == 8'(TO_CYC - 1));

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (mem_if.imem_ack) w_state_nxt = S_DECODE;
                else if (w_timeout) w_state_nxt = S_ERROR;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_alu || w_jal)     w_state_nxt = S_WB;
        else if (w_lw || w_sw)  w_state_nxt = S_MEM;
        else if (w_sys)         w_state_nxt = S_HALT;
`ifdef CU_TRAP_EN
        else if (w_ill)         w_state_nxt = S_ERROR;
`endif
        else                    w_state_nxt = S_FETCH;
      end
      S_MEM:    if (mem_if.dmem_ack) w_state_nxt = w_lw ? S_WB : S_FETCH;
                else if (w_timeout) w_state_nxt = S_ERROR;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   if (i_resume) w_state_nxt = S_FETCH;
      S_ERROR:  w_state_nxt = S_ERROR;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // State, wait counter, latched opcode and trap cause.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_cnt     <= 8'd0;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_wait && !w_ack) ? r_cnt + 8'd1 : 8'd0;
      if (r_state == S_DECODE) r_op <= i_op;
      if ((r_state == S_EXEC) && (w_state_nxt == S_ERROR)) r_illegal <= 1'b1;
    end
  end

  // Outputs are forced to zero while reset is held so nothing leaks before FETCH starts.
  assign w_run    = !i_rst;
  assign w_fld_en = w_run && ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                              (r_state == S_MEM) || (r_state == S_WB));

  assign mem_if.imem_req = w_run && (r_state == S_FETCH);
  assign mem_if.dmem_req = w_run && (r_state == S_MEM);
  assign o_irwrite  = w_run && (r_state == S_DECODE);
  assign o_pcwrite  = w_run && (r_state == S_DECODE);
  assign o_brvalid  = w_run && (r_state == S_EXEC) && w_brv_op;
  assign o_regwt    = w_run && (r_state == S_WB);
  assign o_rdata    = w_run && (r_state == S_MEM) && w_lw;
  assign o_wdata    = w_run && (r_state == S_MEM) && w_sw;
  assign o_halted   = w_run && (r_state == S_HALT);
  assign o_err      = w_run && (r_state == S_ERROR);
  assign o_illegal  = w_run && (r_state == S_ERROR) && r_illegal;
  assign o_regdst   = w_fld_en ? w_regdst   : 2'b00;
  assign o_reginsrc = w_fld_en ? w_reginsrc : 2'b00;
  assign o_brtype   = w_fld_en ? w_brtype   : 2'b00;
  assign o_pcsrc    = w_fld_en ? w_pcsrc    : 2'b00;
  assign o_fnc      = w_fld_en ? w_fnc      : 2'b00;
  assign o_lgc      = w_fld_en ? w_lgc      : 2'b00;
  assign o_shift    = w_fld_en ? w_shift    : 2'b00;
  assign o_alusrc   = w_fld_en && w_alusrc;
  assign o_addsub   = w_fld_en && w_addsub;

endmodule
